md_unit: RTL and testbench

- Parametrised successor to the E-stage multiply/divide unit.
- Holds architectural HI/LO and executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo with a start/busy handshake.
- The stall unit uses the handshake to hold D-stage HI/LO consumers.
- New relative to the current unit: configurable width and multiply latency, a true iterative divider, accumulate ops, and a cancel input for the P7 exception flush.

---
 rtl/md_unit_pkg.sv | 41 ++++
 rtl/md_unit_if.sv | 27 ++
 rtl/md_div_core.sv | 56 +++++
 rtl/md_unit.sv | 179 +++++++++++++++++
 tb/tb_md_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// states and small decode predicates used by the unit and its users.
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV_ITER,
    DIV_FIX
  } md_state_e;

  // Multiply family: plain products and the accumulate variants.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == MADD) ||
           (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Ops that interpret their operands as two's complement.
  function automatic logic is_signed(input logic [3:0] op);
    return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the E stage / stall unit and md_unit.
//   start, op, in1, in2, cancel : launch request and flush (master -> unit)
//   busy, done                  : handshake status (unit -> master)
//   hi_out, lo_out              : architectural HI/LO (unit -> master)
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, in1, in2, cancel,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, in1, in2, cancel,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/md_div_core.sv
// Unsigned restoring divider producing one quotient bit per step.
//   clk, reset          : clock, asynchronous active-low reset
//   load                : capture dividend/divisor, clear partial remainder
//   step                : perform one shift/subtract iteration
//   dividend, divisor   : unsigned operands (sampled on load)
//   quotient, remainder : valid after WIDTH steps
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Partial remainder stays below the divisor, so one extra bit is enough
  // for the trial subtraction; diff[WIDTH] set means the subtraction borrowed.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding architectural HI/LO.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : md_unit_if.slave -- start/op/in1/in2/cancel in,
//            busy/done/hi_out/lo_out out
// Multiplies commit after MULT_LAT busy cycles; divides take WIDTH iterations
// plus one sign-fix cycle. cancel aborts any in-flight op without touching
// HI/LO and suppresses a launch on the same edge.
module md_unit
  import md_defs::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int MAXC  = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
  localparam int CNT_W = $clog2(MAXC + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         mop_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] a_ext, b_ext, acc, mul_res;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               q_neg_q, r_neg_q, dz_q;
  logic               sgn1, sgn2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  logic mul_launch, div_load, div_step, cnt_inc;
  logic mul_commit, div_commit, mthi_wr, mtlo_wr;

  // Operand conditioning at launch: sign-extended copies feed the product,
  // magnitudes feed the unsigned divider core.
  always_comb begin
    sgn1   = is_signed(bus.op) & bus.in1[WIDTH-1];
    sgn2   = is_signed(bus.op) & bus.in2[WIDTH-1];
    a_ext  = {{WIDTH{sgn1}}, bus.in1};
    b_ext  = {{WIDTH{sgn2}}, bus.in2};
    prod_d = a_ext * b_ext;
    mag1   = sgn1 ? -bus.in1 : bus.in1;
    mag2   = sgn2 ? -bus.in2 : bus.in2;
  end

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo),
    .remainder (rem)
  );

  // Accumulate ops read HI/LO at commit, not at launch.
  always_comb begin
    acc = {hi_q, lo_q};
    case (mop_q)
      MADD, MADDU: mul_res = acc + prod_q;
      MSUB, MSUBU: mul_res = acc - prod_q;
      default:     mul_res = prod_q;
    endcase
    quo_fix = q_neg_q ? -quo : quo;
    rem_fix = r_neg_q ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mul_launch = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    cnt_inc    = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    mthi_wr    = 1'b0;
    mtlo_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (is_mul(bus.op)) begin
            state_d    = MUL;
            mul_launch = 1'b1;
          end else if (is_div(bus.op)) begin
            state_d  = DIV_ITER;
            div_load = 1'b1;
          end else if (bus.op == MTHI) begin
            mthi_wr = 1'b1;
          end else if (bus.op == MTLO) begin
            mtlo_wr = 1'b1;
          end
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MULT_LAT)) begin
          state_d    = IDLE;
          mul_commit = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DIV_ITER: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          div_step = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = IDLE;
        if (!bus.cancel) div_commit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiply counter starts at 1 so the commit edge is exactly MULT_LAT
  // edges after launch; the divide counter counts completed iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      prod_q  <= '0;
      mop_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (mul_launch) begin
        prod_q <= prod_d;
        mop_q  <= bus.op;
        cnt_q  <= CNT_W'(1);
      end else if (div_load) begin
        q_neg_q <= sgn1 ^ sgn2;
        r_neg_q <= sgn1;
        dz_q    <= (bus.in2 == '0);
        cnt_q   <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= mul_commit | div_commit;
      if (mthi_wr) hi_q <= bus.in1;
      if (mtlo_wr) lo_q <= bus.in1;
      if (mul_commit) {hi_q, lo_q} <= mul_res;
      if (div_commit && !dz_q) begin
        lo_q <= quo_fix;
        hi_q <= rem_fix;
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops on a
// 32-bit/5-cycle instance and an 8-bit/1-cycle instance, checked against an
// arithmetic reference model of HI/LO, latency and done behaviour.
module tb_md_unit;
  import md_defs::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bus32 ();
  md_unit_if #(.WIDTH(8))  bus8 ();

  md_unit #(.WIDTH(32), .MULT_LAT(5)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32.slave));
  md_unit #(.WIDTH(8),  .MULT_LAT(1)) dut8  (.clk(clk), .reset(rst_n), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;
  logic [63:0] mh [2];
  logic [63:0] ml [2];

  function automatic int width_of(input int inst);
    return (inst == 0) ? 32 : 8;
  endfunction

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 5 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input bit s, input logic [3:0] o,
                       input logic [63:0] a, input logic [63:0] b, input bit c);
    if (inst == 0) begin
      bus32.start = s; bus32.op = o; bus32.in1 = a[31:0]; bus32.in2 = b[31:0]; bus32.cancel = c;
    end else begin
      bus8.start = s; bus8.op = o; bus8.in1 = a[7:0]; bus8.in2 = b[7:0]; bus8.cancel = c;
    end
  endtask

  task automatic sample(input int inst, output logic bsy, output logic dn,
                        output logic [63:0] h, output logic [63:0] l);
    if (inst == 0) begin
      bsy = bus32.busy; dn = bus32.done; h = 64'(bus32.hi_out); l = 64'(bus32.lo_out);
    end else begin
      bsy = bus8.busy; dn = bus8.done; h = 64'(bus8.hi_out); l = 64'(bus8.lo_out);
    end
  endtask

  function automatic longint sext(input logic [63:0] v, input int w, input bit sg);
    if (sg && v[w-1]) return longint'(v) - (longint'(1) <<< w);
    return longint'(v);
  endfunction

  // Reference: what HI/LO become, how many busy cycles, and whether done pulses.
  function automatic void model(input int inst, input logic [3:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] nh, output logic [63:0] nl,
                                output int lat, output bit dn);
    int w;
    logic [63:0] mask, mask2, acc, prod, r;
    longint sa, sb;
    bit sg, mulf;
    w     = width_of(inst);
    mask  = (64'd1 << w) - 64'd1;
    mask2 = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    sg    = (op == 4'd1) || (op == 4'd3) || (op == 4'd7) || (op == 4'd9);
    sa    = sext(a & mask, w, sg);
    sb    = sext(b & mask, w, sg);
    acc   = (mh[inst] << w) | ml[inst];
    prod  = 64'(sa * sb);
    nh = mh[inst]; nl = ml[inst]; lat = 0; dn = 0; mulf = 1; r = prod;
    case (op)
      4'd1, 4'd2:  r = prod;
      4'd7, 4'd8:  r = acc + prod;
      4'd9, 4'd10: r = acc - prod;
      default:     mulf = 0;
    endcase
    if (mulf) begin
      r = r & mask2; nh = (r >> w) & mask; nl = r & mask; lat = lat_of(inst); dn = 1;
    end else if (op == 4'd3 || op == 4'd4) begin
      lat = w + 1; dn = 1;
      if (sb != 0) begin
        nl = 64'(sa / sb) & mask;
        nh = 64'(sa % sb) & mask;
      end
    end else if (op == 4'd5) begin
      nh = a & mask;
    end else if (op == 4'd6) begin
      nl = a & mask;
    end
  endfunction

  function automatic logic [63:0] rnd_operand(input int inst);
    int w;
    logic [63:0] mask;
    w = width_of(inst);
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return mask;
      3: return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // cancel_at: 0 none, <0 together with start, >0 during that busy cycle.
  // poke_at: >0 pulses a start (MTLO) during that busy cycle.
  task automatic run_op(input int inst, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int cancel_at, input int poke_at,
                        input string tag);
    logic [63:0] eh, el, h, l;
    logic bsy, dn;
    int lat, n;
    bit edn;
    model(inst, op, a, b, eh, el, lat, edn);
    if (cancel_at < 0 || (cancel_at > 0 && cancel_at <= lat)) begin
      eh = mh[inst]; el = ml[inst]; edn = 0;
      lat = (cancel_at < 0) ? 0 : cancel_at;
    end
    @(negedge clk);
    drive(inst, 1'b1, op, a, b, cancel_at < 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      sample(inst, bsy, dn, h, l);
      if (!bsy) break;
      n++;
      chk({tag, "/done_in_busy"}, 64'(dn), 64'd0);
      chk({tag, "/hi_held"}, h, mh[inst]);
      drive(inst, n == poke_at, MTLO, rnd_operand(inst), 64'd0, n == cancel_at);
    end
    drive(inst, 1'b0, MD_NONE, 64'd0, 64'd0, 1'b0);
    chk({tag, "/busy_cycles"}, 64'(n), 64'(lat));
    chk({tag, "/done"}, 64'(dn), 64'(edn));
    chk({tag, "/hi"}, h, eh);
    chk({tag, "/lo"}, l, el);
    mh[inst] = eh;
    ml[inst] = el;
    @(negedge clk);
    sample(inst, bsy, dn, h, l);
    chk({tag, "/done_len"}, 64'(dn), 64'd0);
  endtask

  initial begin
    logic bsy, dn, seen;
    logic [63:0] h, l;
    int ca, pa;
    rst_n = 1'b0;
    drive(0, 1'b0, MD_NONE, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, MD_NONE, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin mh[i] = 64'd0; ml[i] = 64'd0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sample(i, bsy, dn, h, l);
      chk("rst/busy", 64'(bsy), 64'd0);
      chk("rst/done", 64'(dn), 64'd0);
      chk("rst/hi", h, 64'd0);
      chk("rst/lo", l, 64'd0);
    end
    rst_n = 1'b1;

    run_op(0, MULT,  64'hFFFFFFFD, 64'd7, 0, 0, "mult");
    run_op(0, MULTU, 64'hFFFFFFFD, 64'd7, 0, 0, "multu");
    run_op(0, DIV,   64'hFFFFFFF9, 64'd2, 0, 0, "div_neg");
    run_op(0, DIVU,  64'd100, 64'd7, 0, 0, "divu");
    run_op(0, MTHI,  64'h11, 64'd0, 0, 0, "mthi");
    run_op(0, MTLO,  64'h22, 64'd0, 0, 0, "mtlo");
    run_op(0, DIV,   64'd5, 64'd0, 0, 0, "div_zero");
    run_op(0, DIV,   64'h80000000, 64'hFFFFFFFF, 0, 0, "div_ovf");
    run_op(0, MTLO,  64'hFFFFFFFF, 64'd0, 0, 0, "mtlo");
    run_op(0, MTHI,  64'd0, 64'd0, 0, 0, "mthi");
    run_op(0, MADD,  64'd1, 64'd1, 0, 0, "madd");
    run_op(0, MTHI,  64'd0, 64'd0, 0, 0, "mthi");
    run_op(0, MTLO,  64'd0, 64'd0, 0, 0, "mtlo");
    run_op(0, MSUBU, 64'd1, 64'd1, 0, 0, "msubu");
    run_op(0, MTHI,  64'd5, 64'd0, 0, 0, "mthi");
    run_op(0, MTLO,  64'd5, 64'd0, 0, 0, "mtlo");
    run_op(0, MULT,  64'd3, 64'd4, 3, 0, "mult_cancel");
    run_op(0, MULT,  64'd9, 64'd9, 0, 2, "mult_poke");
    run_op(0, DIV,   64'hFFFFFF9C, 64'd7, 0, 20, "div_poke");
    run_op(0, DIVU,  64'd77, 64'd5, 12, 0, "div_cancel");
    run_op(0, MTLO,  64'hABC, 64'd0, -1, 0, "mtlo_cancel");
    run_op(0, MD_NONE, 64'h1234, 64'd1, 0, 0, "none");
    run_op(0, 4'd13, 64'h1234, 64'd1, 0, 0, "undef");

    run_op(1, DIV,  64'h80, 64'hFF, 0, 0, "div8");
    run_op(1, MULT, 64'h10, 64'h10, 0, 0, "mult8");
    run_op(1, MSUB, 64'h7F, 64'h80, 1, 0, "msub8_cancel");

    for (int inst = 0; inst < 2; inst++) begin
      for (int it = 0; it < 30; it++) begin
        case ($urandom_range(0, 9))
          0: ca = -1;
          1: ca = int'($urandom_range(1, 8));
          default: ca = 0;
        endcase
        pa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
        run_op(inst, 4'($urandom_range(0, 15)), rnd_operand(inst), rnd_operand(inst),
               ca, pa, "rand");
      end
    end

    // Asynchronous reset in the middle of a divide.
    run_op(0, MTHI, 64'h33, 64'd0, 0, 0, "mthi");
    run_op(0, MTLO, 64'h44, 64'd0, 0, 0, "mtlo");
    @(negedge clk);
    drive(0, 1'b1, DIV, 64'd100, 64'd3, 1'b0);
    repeat (10) begin
      @(negedge clk);
      drive(0, 1'b0, MD_NONE, 64'd0, 64'd0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    sample(0, bsy, dn, h, l);
    chk("rst_mid/busy", 64'(bsy), 64'd0);
    chk("rst_mid/hi", h, 64'd0);
    chk("rst_mid/lo", l, 64'd0);
    for (int i = 0; i < 2; i++) begin mh[i] = 64'd0; ml[i] = 64'd0; end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sample(0, bsy, dn, h, l);
      seen = seen | dn | bsy;
    end
    chk("rst_mid/no_done_after", 64'(seen), 64'd0);
    run_op(0, DIVU, 64'd100, 64'd3, 0, 0, "div_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
